elevator_fsm: RTL and testbench
===============================

// Module: elevator_fsm
// PURPOSE
//  4-floor elevator controller for the DE2 top level (top-level entity ElevatorFSM).
//  Latches cabin and hall calls and moves the car one floor at a time with collective (SCAN) scheduling.
//  Opens the door at each requested floor and drives 7-seg and LED status.
// PARAMETERS
//  MOVE_LIMIT  50   clock cycles to travel one floor
//  DOOR_LIMIT  100  clock cycles door stays open
// PORTS
//  CLOCK_50  in   1   system clock; single clock domain, all logic on rising edge
//  SW        in   18  [17]=reset, synchronous, active-high; [3:0]=hall call floor1..4, active-high; others unused
//  KEY       in   4   cabin buttons, active-low; KEY[i] = floor i+1
//  HEX0      out  7   current floor digit, active-low segments {g,f,e,d,c,b,a}
//  LEDG      out  9   [0]=moving up, [1]=moving down, [2]=door open, [3]=idle, [7:4]=one-hot floor, [8]=0
//  LEDR      out  4   pending request bits, floor1..4
// BEHAVIOUR
//  - Reset (SW[17]=1 at a rising edge), with priority over all other inputs, even mid-move or mid-door:
//    - state=IDLE, floor=1 (index 0), dir=up, req=0, counter=0.
//    - All inputs are ignored while reset is held.
//    - Outputs after reset: HEX0=7'b1111001, LEDR=0, LEDG=9'b0_0001_1000.
//  - Request latch: each cycle, req[i] is set if SW[i]=1 or KEY[i]=0.
//    - Cabin and hall calls to the same floor merge into one bit.
//    - req[i] clears only when the door opens at floor i.
//    - A call to the current floor while in DOOR is absorbed and stays cleared.
//  - States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
//    - IDLE:
//      - req[floor] set -> DOOR.
//      - Else any request above the car -> MOVE_UP.
//      - Else any request below the car -> MOVE_DOWN.
//      - If calls exist both above and below, keep the current dir.
//    - MOVE_*: counter runs 0..MOVE_LIMIT-1. On the last count:
//      - floor changes by +/-1 and counter resets.
//      - If req[new floor] is set -> DOOR.
//      - Else, if requests remain ahead -> continue.
//      - Else, if requests exist behind -> reverse.
//      - Else -> IDLE.
//    - DOOR:
//      - On entry, clear req[floor]; the door stays open for DOOR_LIMIT cycles.
//      - At expiry, apply the IDLE decision, preferring the current dir.
//  - Requests arriving mid-move or mid-door are latched and serviced when the car passes or reaches that floor.
//  - Floor saturates at 1..4: no MOVE_DOWN from floor 1, no MOVE_UP from floor 4.
//  - Latency from an edge-latched call: N floors away -> door opens after N*MOVE_LIMIT cycles (+1 decision cycle).
//  - HEX0 encoding: 1=1111001, 2=0100100, 3=0110000, 4=0011001.
//  - Outputs are registered or decoded directly from registered state; no combinational path from inputs.
// TESTING
//  - Reset, then KEY[2]=0 + SW[1]=1 for 1 cycle at floor 1:
//    - door at floor 2 after ~50 cycles, then at floor 3; LEDR reaches 0; HEX0 shows 3.
//  - From floor 1, SW[0]+SW[3] together:
//    - door opens at floor 1 immediately (100 cycles), then 3*50 cycles up, door at floor 4; HEX0=0011001.
//  - At floor 2, KEY[1]=0 + SW[1]=1 together:
//    - single door-open at floor 2; req[1] never reappears.
//  - Call floor 2, then SW[3] pulse 25 cycles into the move:
//    - stop at floor 2 (door 100 cycles), continue to floor 4 without going idle.
//  - Go to floor 3; pulse SW[0] mid-door:
//    - LEDR[0]=1; after the door closes, MOVE_DOWN 2 floors, door at floor 1.
//  - Assert SW[17] during MOVE_UP:
//    - next edge shows floor 1, IDLE, LEDR=0, LEDG=0_0001_1000; a call to floor 1 only opens the door.

Source files
------------

// File: rtl/elevator_fsm.sv
// -----------------------------------------------------------------------------
// elevator_fsm
//   Four-floor elevator controller for the DE2 board. It latches cabin and hall
//   calls, then moves the car one floor at a time using collective (SCAN)
//   scheduling. The door opens at each requested floor. Status is shown on the
//   7-segment display and on the LEDs.
//
// Ports
//   CLOCK_50  in   1   system clock, rising edge
//   SW        in   18  [17] synchronous active-high reset, [3:0] hall calls
//                      for floors 1..4 (active-high), other bits unused
//   KEY       in   4   cabin buttons, active-low, KEY[i] = floor i+1
//   HEX0      out  7   current floor digit, active-low {g,f,e,d,c,b,a}
//   LEDG      out  9   [0] moving up, [1] moving down, [2] door open,
//                      [3] idle, [7:4] one-hot floor, [8] tied low
//   LEDR      out  4   pending request bits, floors 1..4
//
// Every output is decoded from registered state only, so LEDG[3:0] doubles as
// a one-hot view of the FSM state.
// -----------------------------------------------------------------------------
module elevator_fsm #(
  parameter int MOVE_LIMIT = 50,   // cycles to travel one floor
  parameter int DOOR_LIMIT = 100   // cycles the door stays open
) (
  input  logic        CLOCK_50,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  output logic [6:0]  HEX0,
  output logic [8:0]  LEDG,
  output logic [3:0]  LEDR
);

  localparam int CNT_W = $clog2((MOVE_LIMIT > DOOR_LIMIT) ? MOVE_LIMIT : DOOR_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [1:0]       floor, floor_next;   // floor index 0..3 = floors 1..4
  logic             dir, dir_next;       // 1 = up, 0 = down
  logic [3:0]       req, req_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic       rst;
  logic [3:0] calls;
  logic       unused_sw;

  assign rst       = SW[17];
  assign calls     = SW[3:0] | ~KEY;   // cabin and hall calls merge per floor
  assign unused_sw = ^SW[16:4];

  // Scheduling decision at floor f. A request at f opens the door. If calls
  // exist on both sides, the car keeps its travel direction d. A car at
  // floor 1 has no "below" bits, and a car at floor 4 has no "above" bits,
  // so the floor saturates by construction.
  function automatic state_t pick(input logic [1:0] f, input logic d,
                                  input logic [3:0] r);
    logic [3:0] above_mask, below_mask;
    logic       above, below;
    above_mask = 4'b1110 << f;
    below_mask = ~(4'b1111 << f);
    above      = |(r & above_mask);
    below      = |(r & below_mask);
    if (r[f])                pick = DOOR;
    else if (above && below) pick = d ? MOVE_UP : MOVE_DOWN;
    else if (above)          pick = MOVE_UP;
    else if (below)          pick = MOVE_DOWN;
    else                     pick = IDLE;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= IDLE;
      floor <= 2'd0;
      dir   <= 1'b1;
      req   <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      floor <= floor_next;
      dir   <= dir_next;
      req   <= req_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    floor_next = floor;
    dir_next   = dir;
    cnt_next   = cnt + 1'b1;
    req_next   = req | calls;

    case (state)
      IDLE: begin
        state_next = pick(floor, dir, req);
        cnt_next   = '0;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (cnt == CNT_W'(MOVE_LIMIT - 1)) begin
          floor_next = (state == MOVE_UP) ? floor + 2'd1 : floor - 2'd1;
          // Arrival: stop if called here, else keep going, reverse, or idle.
          state_next = pick(floor_next, dir, req);
          cnt_next   = '0;
        end
      end
      DOOR: begin
        if (cnt == CNT_W'(DOOR_LIMIT - 1)) begin
          state_next = pick(floor, dir, req);
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (state_next == MOVE_UP)   dir_next = 1'b1;
    if (state_next == MOVE_DOWN) dir_next = 1'b0;

    // The request at the door floor is cleared on entry. It stays cleared
    // while the door is open, so a call to that floor is absorbed then.
    if (state == DOOR || state_next == DOOR)
      req_next[floor_next] = 1'b0;
  end

  always_comb begin
    case (floor)
      2'd0:    HEX0 = 7'b1111001;
      2'd1:    HEX0 = 7'b0100100;
      2'd2:    HEX0 = 7'b0110000;
      default: HEX0 = 7'b0011001;
    endcase
  end

  assign LEDG = {1'b0, 4'b0001 << floor,
                 state == IDLE, state == DOOR, state == MOVE_DOWN, state == MOVE_UP};
  assign LEDR = req;

endmodule

// File: tb/tb_elevator_fsm.sv
// -----------------------------------------------------------------------------
// tb_elevator_fsm
//   Directed bench for elevator_fsm, using the default limits (50/100).
//   Inputs change 1 time unit after a rising edge. Outputs are checked at
//   that same point, so every expected value refers to the state after the
//   last edge. Cycle counts below are hand-derived: a latched call takes one
//   IDLE decision edge, each floor takes 50 edges, and a door stays open for
//   100 edges.
// -----------------------------------------------------------------------------
module tb_elevator_fsm;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] sw;
  logic [3:0]  key;
  logic [6:0]  hex0;
  logic [8:0]  ledg;
  logic [3:0]  ledr;

  elevator_fsm dut (
    .CLOCK_50 (clk),
    .SW       (sw),
    .KEY      (key),
    .HEX0     (hex0),
    .LEDG     (ledg),
    .LEDR     (ledr)
  );

  localparam logic [3:0] S_UP = 4'b0001;
  localparam logic [3:0] S_DN = 4'b0010;
  localparam logic [3:0] S_DR = 4'b0100;
  localparam logic [3:0] S_ID = 4'b1000;

  int errors = 0;
  int checks = 0;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex_of(input int fl);
    case (fl)
      1:       hex_of = 7'b1111001;
      2:       hex_of = 7'b0100100;
      3:       hex_of = 7'b0110000;
      default: hex_of = 7'b0011001;
    endcase
  endfunction

  // Checks the full car status: state one-hot, floor (1..4) and pending requests.
  task automatic check_car(input string tag, input logic [3:0] st, input int fl,
                           input logic [3:0] req);
    logic [3:0] oh;
    oh = 4'b0001 << (fl - 1);
    check({tag, "/ledg"}, {23'd0, ledg}, {23'd0, 1'b0, oh, st});
    check({tag, "/hex0"}, {25'd0, hex0}, {25'd0, hex_of(fl)});
    check({tag, "/ledr"}, {28'd0, ledr}, {28'd0, req});
  endtask

  initial begin
    sw  = '0;
    key = 4'hF;

    // Reset: all state returns to floor 1, idle, no requests.
    sw[17] = 1'b1;
    tick(2);
    check_car("reset", S_ID, 1, 4'b0000);
    check("reset_ledg_const", {23'd0, ledg}, 32'h18);
    sw[17] = 1'b0;

    // KEY[2] + SW[1] for one cycle: the car stops at 2, then at 3.
    key[2] = 1'b0; sw[1] = 1'b1;
    tick(1);
    key = 4'hF; sw = '0;
    check_car("a_latch", S_ID, 1, 4'b0110);
    tick(1);
    check_car("a_start", S_UP, 1, 4'b0110);
    tick(49);
    check_car("a_pre2", S_UP, 1, 4'b0110);
    tick(1);
    check_car("a_door2", S_DR, 2, 4'b0100);
    tick(99);
    check_car("a_door2_end", S_DR, 2, 4'b0100);
    tick(1);
    check_car("a_to3", S_UP, 2, 4'b0100);
    tick(50);
    check_car("a_door3", S_DR, 3, 4'b0000);
    tick(100);
    check_car("a_idle3", S_ID, 3, 4'b0000);

    // At floor 3: open the door, then pulse SW[0] while the door is open.
    key[2] = 1'b0;
    tick(1);
    key = 4'hF;
    check_car("b_latch3", S_ID, 3, 4'b0100);
    tick(1);
    check_car("b_door3", S_DR, 3, 4'b0000);
    tick(50);
    sw[0] = 1'b1;
    tick(1);
    sw = '0;
    check_car("b_mid_door", S_DR, 3, 4'b0001);
    tick(48);
    check_car("b_door_end", S_DR, 3, 4'b0001);
    tick(1);
    check_car("b_down", S_DN, 3, 4'b0001);
    tick(50);
    check_car("b_pass2", S_DN, 2, 4'b0001);
    tick(50);
    check_car("b_door1", S_DR, 1, 4'b0000);
    tick(100);
    check_car("b_idle1", S_ID, 1, 4'b0000);

    // SW[0] + SW[3] at floor 1: the door opens at once, then the car goes to 4.
    sw[0] = 1'b1; sw[3] = 1'b1;
    tick(1);
    sw = '0;
    check_car("c_latch", S_ID, 1, 4'b1001);
    tick(1);
    check_car("c_door1", S_DR, 1, 4'b1000);
    tick(100);
    check_car("c_up", S_UP, 1, 4'b1000);
    tick(149);
    check_car("c_pre4", S_UP, 3, 4'b1000);
    tick(1);
    check_car("c_door4", S_DR, 4, 4'b0000);
    tick(100);
    check_car("c_idle4", S_ID, 4, 4'b0000);

    // Go to floor 2, passing floor 3 without stopping.
    sw[1] = 1'b1;
    tick(1);
    sw = '0;
    tick(1);
    check_car("d_down", S_DN, 4, 4'b0010);
    tick(100);
    check_car("d_door2", S_DR, 2, 4'b0000);
    tick(100);
    check_car("d_idle2", S_ID, 2, 4'b0000);

    // At floor 2: KEY[1] + SW[1] together give one door opening. A repeated
    // call while the door is open is absorbed.
    key[1] = 1'b0; sw[1] = 1'b1;
    tick(1);
    key = 4'hF; sw = '0;
    check_car("e_merge", S_ID, 2, 4'b0010);
    tick(1);
    check_car("e_door", S_DR, 2, 4'b0000);
    tick(10);
    sw[1] = 1'b1;
    tick(5);
    sw = '0;
    check_car("e_absorb", S_DR, 2, 4'b0000);
    tick(84);
    check_car("e_door_end", S_DR, 2, 4'b0000);
    tick(1);
    check_car("e_idle", S_ID, 2, 4'b0000);
    tick(5);
    check_car("e_no_reopen", S_ID, 2, 4'b0000);

    // Back to floor 1.
    sw[0] = 1'b1;
    tick(1);
    sw = '0;
    tick(51);
    check_car("f_door1", S_DR, 1, 4'b0000);
    tick(100);
    check_car("f_idle1", S_ID, 1, 4'b0000);

    // Call floor 2, then SW[3] 25 cycles into the move: stop at 2, continue to 4.
    key[1] = 1'b0;
    tick(1);
    key = 4'hF;
    tick(1);
    check_car("g_up", S_UP, 1, 4'b0010);
    tick(25);
    sw[3] = 1'b1;
    tick(1);
    sw = '0;
    check_car("g_late_call", S_UP, 1, 4'b1010);
    tick(24);
    check_car("g_door2", S_DR, 2, 4'b1000);
    tick(100);
    check_car("g_continue", S_UP, 2, 4'b1000);
    tick(100);
    check_car("g_door4", S_DR, 4, 4'b0000);
    tick(100);
    check_car("g_idle4", S_ID, 4, 4'b0000);

    // Reset during MOVE_UP beats the move. Inputs are ignored while reset is held.
    sw[17] = 1'b1;
    tick(1);
    sw[17] = 1'b0;
    key[3] = 1'b0;
    tick(1);
    key = 4'hF;
    tick(1);
    check_car("h_up", S_UP, 1, 4'b1000);
    tick(70);
    check_car("h_mid_move", S_UP, 2, 4'b1000);
    sw[17] = 1'b1; sw[2] = 1'b1;
    tick(1);
    check_car("h_reset", S_ID, 1, 4'b0000);
    tick(1);
    check_car("h_reset_hold", S_ID, 1, 4'b0000);
    sw = '0;
    sw[0] = 1'b1;
    tick(1);
    sw = '0;
    check_car("h_call1", S_ID, 1, 4'b0001);
    tick(1);
    check_car("h_door1", S_DR, 1, 4'b0000);
    tick(100);
    check_car("h_idle1", S_ID, 1, 4'b0000);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
